ysyx_22050710_axi4full_burst_master: RTL and testbench

//  AXI4-full master bridging the IF/MEM/cache request port to the system bus. Supports single-beat

---
 rtl/ysyx_22050710_axi4full_burst_master.sv | 233 +++++++++++++++++++++++
 tb/tb_ysyx_22050710_axi4full_burst_master.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22050710_axi4full_burst_master.sv
// AXI4-full master for the cache/IF/MEM request port: single-beat accesses and
// INCR line bursts, one transaction in flight, with sticky response/RLAST error reporting.
module ysyx_22050710_axi4full_burst_master #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int AXI_ID     = 0,
    parameter int BURST_LEN  = 4,
    parameter int LINE_WIDTH = DATA_WIDTH * BURST_LEN
) (
    input  logic                    i_aclk,
    input  logic                    i_areset,
    // requester port
    input  logic                    i_rw_req,
    input  logic                    i_rw_wr,
    input  logic                    i_rw_burst,
    input  logic                    i_rw_inst,
    input  logic [2:0]              i_rw_size,
    input  logic [ADDR_WIDTH-1:0]   i_rw_addr,
    input  logic [DATA_WIDTH/8-1:0] i_rw_wstrb,
    input  logic [LINE_WIDTH-1:0]   i_rw_wline,
    output logic                    o_rw_addr_ok,
    output logic                    o_rw_data_ok,
    output logic [LINE_WIDTH-1:0]   o_rw_rline,
    output logic                    o_rw_err,
    // AW channel
    output logic [ID_WIDTH-1:0]     o_awid,
    output logic [ADDR_WIDTH-1:0]   o_awaddr,
    output logic [7:0]              o_awlen,
    output logic [2:0]              o_awsize,
    output logic [1:0]              o_awburst,
    output logic                    o_awlock,
    output logic [3:0]              o_awcache,
    output logic [2:0]              o_awprot,
    output logic                    o_awvalid,
    input  logic                    i_awready,
    // W channel
    output logic [DATA_WIDTH-1:0]   o_wdata,
    output logic [DATA_WIDTH/8-1:0] o_wstrb,
    output logic                    o_wlast,
    output logic                    o_wvalid,
    input  logic                    i_wready,
    // B channel
    input  logic [1:0]              i_bresp,
    input  logic                    i_bvalid,
    output logic                    o_bready,
    // AR channel
    output logic [ID_WIDTH-1:0]     o_arid,
    output logic [ADDR_WIDTH-1:0]   o_araddr,
    output logic [7:0]              o_arlen,
    output logic [2:0]              o_arsize,
    output logic [1:0]              o_arburst,
    output logic                    o_arlock,
    output logic [3:0]              o_arcache,
    output logic [2:0]              o_arprot,
    output logic                    o_arvalid,
    input  logic                    i_arready,
    // R channel
    input  logic [DATA_WIDTH-1:0]   i_rdata,
    input  logic [1:0]              i_rresp,
    input  logic                    i_rlast,
    input  logic                    i_rvalid,
    output logic                    o_rready
);

    localparam int STRB_W   = DATA_WIDTH / 8;
    localparam int IDX_W    = $clog2(BURST_LEN);
    localparam int CNT_W    = IDX_W + 1;
    localparam int LINE_OFF = $clog2(LINE_WIDTH / 8);

    localparam logic [2:0] BEAT_SIZE   = 3'($clog2(STRB_W));
    localparam logic [7:0] BURST_AXLEN = 8'(BURST_LEN - 1);
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;

    typedef enum logic [2:0] {
        IDLE,
        RADDR,
        RDATA,
        WADDR,
        WDATA,
        WRESP
    } state_t;

    state_t state, state_nxt;

    logic                  req_wr;
    logic                  req_burst;
    logic                  req_inst;
    logic [2:0]            req_size;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [STRB_W-1:0]     req_wstrb;
    logic [LINE_WIDTH-1:0] req_wline;

    logic [CNT_W-1:0]      beat_cnt;
    logic [IDX_W-1:0]      beat_sel;
    logic                  last_beat;
    logic                  accept;
    logic                  ar_fire, aw_fire, r_fire, w_fire, b_fire;
    logic                  resp_err;

    logic [ADDR_WIDTH-1:0] ax_addr;
    logic [7:0]            ax_len;
    logic [2:0]            ax_size;
    logic [2:0]            ax_prot;

    assign accept  = (state == IDLE) && i_rw_req;
    assign ar_fire = (state == RADDR) && i_arready;
    assign aw_fire = (state == WADDR) && i_awready;
    assign r_fire  = (state == RDATA) && i_rvalid;
    assign w_fire  = (state == WDATA) && i_wready;
    assign b_fire  = (state == WRESP) && i_bvalid;

    // While reset is held the FSM sits in IDLE, so the accept strobe must be masked.
    assign o_rw_addr_ok = accept && !i_areset;

    assign beat_sel  = beat_cnt[IDX_W-1:0];
    assign last_beat = (8'(beat_cnt) == ax_len);

    assign ax_addr = req_burst ? {req_addr[ADDR_WIDTH-1:LINE_OFF], {LINE_OFF{1'b0}}} : req_addr;
    assign ax_len  = req_burst ? BURST_AXLEN : 8'd0;
    assign ax_size = req_burst ? BEAT_SIZE : req_size;
    assign ax_prot = {req_inst, 2'b00};

    assign o_awid    = ID_WIDTH'(AXI_ID);
    assign o_awaddr  = ax_addr;
    assign o_awlen   = ax_len;
    assign o_awsize  = ax_size;
    assign o_awburst = BURST_INCR;
    assign o_awlock  = 1'b0;
    assign o_awcache = 4'd0;
    assign o_awprot  = ax_prot;

    assign o_arid    = ID_WIDTH'(AXI_ID);
    assign o_araddr  = ax_addr;
    assign o_arlen   = ax_len;
    assign o_arsize  = ax_size;
    assign o_arburst = BURST_INCR;
    assign o_arlock  = 1'b0;
    assign o_arcache = 4'd0;
    assign o_arprot  = ax_prot;

    assign o_wdata = req_wline[int'(beat_sel) * DATA_WIDTH +: DATA_WIDTH];
    assign o_wstrb = req_burst ? {STRB_W{1'b1}} : req_wstrb;
    assign o_wlast = last_beat;

    // A bad response or an RLAST that disagrees with our own beat count flags the transaction.
    assign resp_err = (r_fire && ((i_rresp != RESP_OKAY) || (i_rlast != last_beat)))
                   || (b_fire && (i_bresp != RESP_OKAY));

    always_comb begin
        state_nxt = state;
        o_arvalid = 1'b0;
        o_rready  = 1'b0;
        o_awvalid = 1'b0;
        o_wvalid  = 1'b0;
        o_bready  = 1'b0;
        unique case (state)
            IDLE: begin
                if (i_rw_req) state_nxt = i_rw_wr ? WADDR : RADDR;
            end
            RADDR: begin
                o_arvalid = 1'b1;
                if (i_arready) state_nxt = RDATA;
            end
            RDATA: begin
                o_rready = 1'b1;
                if (i_rvalid && last_beat) state_nxt = IDLE;
            end
            WADDR: begin
                o_awvalid = 1'b1;
                if (i_awready) state_nxt = WDATA;
            end
            WDATA: begin
                o_wvalid = 1'b1;
                if (i_wready && last_beat) state_nxt = WRESP;
            end
            WRESP: begin
                o_bready = 1'b1;
                if (i_bvalid) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_aclk or posedge i_areset) begin
        if (i_areset) begin
            state        <= IDLE;
            beat_cnt     <= '0;
            o_rw_data_ok <= 1'b0;
            o_rw_err     <= 1'b0;
        end else begin
            state        <= state_nxt;
            o_rw_data_ok <= (r_fire && last_beat) || b_fire;
            if (accept) begin
                beat_cnt <= '0;
            end else if (r_fire || w_fire) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
            if (accept) begin
                o_rw_err <= 1'b0;
            end else if (resp_err) begin
                o_rw_err <= 1'b1;
            end
        end
    end

    // Request snapshot; the requester is free to change its inputs after addr_ok.
    always_ff @(posedge i_aclk) begin
        if (accept) begin
            req_wr    <= i_rw_wr;
            req_burst <= i_rw_burst;
            req_inst  <= i_rw_inst;
            req_size  <= i_rw_size;
            req_addr  <= i_rw_addr;
            req_wstrb <= i_rw_wstrb;
            req_wline <= i_rw_wline;
        end
    end

    always_ff @(posedge i_aclk or posedge i_areset) begin
        if (i_areset) begin
            o_rw_rline <= '0;
        end else if (r_fire) begin
            o_rw_rline[int'(beat_sel) * DATA_WIDTH +: DATA_WIDTH] <= i_rdata;
        end
    end

    // req_wr only steers the FSM at accept time; kept for debug visibility of the active request.
    logic req_wr_unused;
    assign req_wr_unused = req_wr;

endmodule

// File: tb/tb_ysyx_22050710_axi4full_burst_master.sv
// Self-checking bench: directed scenarios plus randomized transactions against
// a transaction-level model of the request port and AXI channel rules.
module tb_ysyx_22050710_axi4full_burst_master;

    localparam int DW         = 64;
    localparam int AW         = 32;
    localparam int IDW        = 4;
    localparam int BL         = 4;
    localparam int LW         = DW * BL;
    localparam int SW         = DW / 8;
    localparam int LINE_BYTES = LW / 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            req, wr, burst, inst;
    logic [2:0]      size;
    logic [AW-1:0]   addr;
    logic [SW-1:0]   wstrb;
    logic [LW-1:0]   wline;
    logic            addr_ok, data_ok, err;
    logic [LW-1:0]   rline;
    logic [IDW-1:0]  awid, arid;
    logic [AW-1:0]   awaddr, araddr;
    logic [7:0]      awlen, arlen;
    logic [2:0]      awsize, arsize, awprot, arprot;
    logic [1:0]      awburst, arburst;
    logic            awlock, arlock;
    logic [3:0]      awcache, arcache;
    logic            awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic            arvalid, arready, rvalid, rready, rlast;
    logic [DW-1:0]   wdata, rdata;
    logic [SW-1:0]   wstrb_o;
    logic [1:0]      bresp, rresp;

    ysyx_22050710_axi4full_burst_master #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IDW), .AXI_ID(0), .BURST_LEN(BL)
    ) dut (
        .i_aclk(clk), .i_areset(rst),
        .i_rw_req(req), .i_rw_wr(wr), .i_rw_burst(burst), .i_rw_inst(inst),
        .i_rw_size(size), .i_rw_addr(addr), .i_rw_wstrb(wstrb), .i_rw_wline(wline),
        .o_rw_addr_ok(addr_ok), .o_rw_data_ok(data_ok), .o_rw_rline(rline), .o_rw_err(err),
        .o_awid(awid), .o_awaddr(awaddr), .o_awlen(awlen), .o_awsize(awsize),
        .o_awburst(awburst), .o_awlock(awlock), .o_awcache(awcache), .o_awprot(awprot),
        .o_awvalid(awvalid), .i_awready(awready),
        .o_wdata(wdata), .o_wstrb(wstrb_o), .o_wlast(wlast), .o_wvalid(wvalid), .i_wready(wready),
        .i_bresp(bresp), .i_bvalid(bvalid), .o_bready(bready),
        .o_arid(arid), .o_araddr(araddr), .o_arlen(arlen), .o_arsize(arsize),
        .o_arburst(arburst), .o_arlock(arlock), .o_arcache(arcache), .o_arprot(arprot),
        .o_arvalid(arvalid), .i_arready(arready),
        .i_rdata(rdata), .i_rresp(rresp), .i_rlast(rlast), .i_rvalid(rvalid), .o_rready(rready)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Transaction-level model state
    logic          cur_burst, cur_inst;
    logic [2:0]    cur_size;
    logic [AW-1:0] cur_addr;
    logic [SW-1:0] cur_wstrb;
    logic [LW-1:0] cur_wline;
    logic [LW-1:0] model_rline;
    logic          exp_err;

    task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] r;
        for (int i = 0; i < LW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [AW-1:0] exp_addr();
        return cur_burst ? AW'(cur_addr - (cur_addr % LINE_BYTES)) : cur_addr;
    endfunction

    function automatic int n_beats();
        return cur_burst ? BL : 1;
    endfunction

    function automatic logic [2:0] exp_size();
        return cur_burst ? 3'($clog2(SW)) : cur_size;
    endfunction

    task automatic issue(input logic w, input logic b, input logic in, input logic [2:0] sz,
                         input logic [AW-1:0] a, input logic [SW-1:0] st, input logic [LW-1:0] ln,
                         input logic hold, input logic expect_now);
        int waited;
        wr = w; burst = b; inst = in; size = sz; addr = a; wstrb = st; wline = ln; req = 1'b1;
        #1;
        waited = 0;
        while (!addr_ok && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("addr_ok", addr_ok, 1'b1);
        if (expect_now) check("addr_ok_same_cycle", waited, 0);
        cur_burst = b; cur_inst = in; cur_size = sz; cur_addr = a; cur_wstrb = st; cur_wline = ln;
        exp_err = 1'b0;
        @(negedge clk);
        check("addr_ok_pulse", addr_ok, 1'b0);
        if (!hold) begin
            req = 1'b0;
            wr = $urandom; burst = $urandom; inst = $urandom; size = $urandom;
            addr = $urandom; wstrb = $urandom; wline = rand_line();
        end
    endtask

    task automatic run_read(input int gap_mode, input int err_beat, input int badlast_beat,
                            input int rst_beat, input logic fixed, input logic [DW-1:0] base);
        int d, gap;
        logic lastb;
        check("arvalid", arvalid, 1'b1);
        check("araddr", araddr, exp_addr());
        check("arlen", arlen, n_beats() - 1);
        check("arsize", arsize, exp_size());
        check("arburst", arburst, 2'b01);
        check("arprot", arprot, {cur_inst, 2'b00});
        check("ar_lock_cache_id", {arlock, arcache, arid}, 0);
        check("awvalid_in_read", awvalid, 1'b0);
        d = $urandom_range(0, 2);
        repeat (d) begin
            @(negedge clk);
            check("arvalid_hold", arvalid, 1'b1);
            check("araddr_hold", araddr, exp_addr());
        end
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        check("arvalid_drop", arvalid, 1'b0);
        for (int k = 0; k < n_beats(); k++) begin
            gap = (gap_mode == 0) ? 0 : (gap_mode == 1) ? 1 : $urandom_range(0, 1);
            repeat (gap) begin
                check("rready_gap", rready, 1'b1);
                @(negedge clk);
            end
            lastb  = (k == n_beats() - 1);
            rvalid = 1'b1;
            rdata  = fixed ? base + DW'(k) : {$urandom, $urandom};
            rresp  = (k == err_beat) ? 2'b10 : 2'b00;
            rlast  = lastb ^ (k == badlast_beat);
            if (k == rst_beat) begin
                #2 rst = 1'b1;
                #1;
                model_rline = '0;
                check("rst_rready", rready, 1'b0);
                check("rst_arvalid", arvalid, 1'b0);
                check("rst_data_ok", data_ok, 1'b0);
                check("rst_err", err, 1'b0);
                check("rst_rline", rline, model_rline);
                check("rst_addr_ok", addr_ok, 1'b0);
                rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
                @(negedge clk);
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            check("rready", rready, 1'b1);
            if (rresp != 2'b00 || rlast != lastb) exp_err = 1'b1;
            model_rline[k*DW +: DW] = rdata;
            @(negedge clk);
            rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
            if (!lastb) check("data_ok_early", data_ok, 1'b0);
        end
        check("r_data_ok", data_ok, 1'b1);
        check("r_rline", rline, model_rline);
        check("r_err", err, exp_err);
        check("rready_drop", rready, 1'b0);
    endtask

    task automatic run_write(input int stall_beat, input logic [1:0] resp);
        int d, stall;
        check("awvalid", awvalid, 1'b1);
        check("awaddr", awaddr, exp_addr());
        check("awlen", awlen, n_beats() - 1);
        check("awsize", awsize, exp_size());
        check("awburst", awburst, 2'b01);
        check("awprot", awprot, {cur_inst, 2'b00});
        check("aw_lock_cache_id", {awlock, awcache, awid}, 0);
        check("arvalid_in_write", arvalid, 1'b0);
        d = $urandom_range(0, 2);
        repeat (d) begin
            @(negedge clk);
            check("awvalid_hold", awvalid, 1'b1);
        end
        awready = 1'b1;
        @(negedge clk);
        awready = 1'b0;
        check("awvalid_drop", awvalid, 1'b0);
        for (int k = 0; k < n_beats(); k++) begin
            stall = (stall_beat < 0) ? $urandom_range(0, 1) : ((k == stall_beat) ? 2 : 0);
            for (int s = 0; s <= stall; s++) begin
                check("wvalid", wvalid, 1'b1);
                check("wdata", wdata, cur_wline[k*DW +: DW]);
                check("wstrb", wstrb_o, cur_burst ? {SW{1'b1}} : cur_wstrb);
                check("wlast", wlast, k == n_beats() - 1);
                if (s < stall) @(negedge clk);
            end
            wready = 1'b1;
            @(negedge clk);
            wready = 1'b0;
        end
        check("wvalid_drop", wvalid, 1'b0);
        check("bready", bready, 1'b1);
        check("w_data_ok_early", data_ok, 1'b0);
        d = $urandom_range(0, 2);
        repeat (d) begin
            @(negedge clk);
            check("bready_hold", bready, 1'b1);
        end
        bvalid = 1'b1;
        bresp  = resp;
        exp_err = (resp != 2'b00);
        @(negedge clk);
        bvalid = 1'b0;
        bresp  = 2'b00;
        check("w_data_ok", data_ok, 1'b1);
        check("w_err", err, exp_err);
        check("w_rline_hold", rline, model_rline);
        check("bready_drop", bready, 1'b0);
    endtask

    task automatic settle();
        @(negedge clk);
        check("data_ok_single", data_ok, 1'b0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int eb, bl_b;
        logic b;
        rst = 1'b1;
        req = 1'b1; wr = 1'b0; burst = 1'b0; inst = 1'b0; size = 3'd0;
        addr = '0; wstrb = '0; wline = '0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00; rlast = 1'b0;
        model_rline = '0;
        exp_err = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_addr_ok", addr_ok, 1'b0);
        check("reset_valids", {arvalid, awvalid, wvalid}, 0);
        check("reset_readys", {rready, bready}, 0);
        check("reset_data_ok", data_ok, 1'b0);
        check("reset_err", err, 1'b0);
        check("reset_rline", rline, model_rline);
        req = 1'b0;
        rst = 1'b0;
        @(negedge clk);

        // 1: single read
        issue(0, 0, 0, 3'd2, 32'h8000_0004, '0, '0, 0, 0);
        run_read(0, -1, -1, -1, 1, 64'h1122_3344_5566_7788);
        check("t1_rline_lo", rline[63:0], 64'h1122_3344_5566_7788);
        settle();

        // 2: burst read with gaps
        issue(0, 1, 1, 3'd0, 32'h8000_1018, '0, '0, 0, 0);
        check("t2_araddr", araddr, 32'h8000_1000);
        run_read(1, -1, -1, -1, 1, 64'hA);
        check("t2_rline", rline, {64'hD, 64'hC, 64'hB, 64'hA});
        settle();

        // 3: burst write, stall on beat 1
        issue(1, 1, 0, 3'd1, 32'h8000_2020, 8'h01, rand_line(), 0, 0);
        run_write(1, 2'b00);
        settle();

        // 4: error cases
        issue(1, 0, 0, 3'd3, 32'h8000_3000, 8'hF0, rand_line(), 0, 0);
        run_write(0, 2'b10);
        check("t4_bresp_err", err, 1'b1);
        settle();
        issue(0, 1, 0, 3'd0, 32'h8000_4000, '0, '0, 0, 0);
        run_read(2, 2, -1, -1, 0, '0);
        check("t4_slverr", err, 1'b1);
        settle();
        issue(0, 1, 0, 3'd0, 32'h8000_5000, '0, '0, 0, 0);
        run_read(0, -1, 1, -1, 0, '0);
        check("t4_early_rlast", err, 1'b1);
        settle();
        issue(0, 1, 0, 3'd0, 32'h8000_5040, '0, '0, 0, 0);
        run_read(0, -1, BL - 1, -1, 0, '0);
        check("t4_missing_rlast", err, 1'b1);
        settle();

        // 5: reset during read beat 2, then single write
        issue(0, 1, 0, 3'd0, 32'h8000_6000, '0, '0, 0, 0);
        run_read(0, -1, -1, 2, 0, '0);
        @(negedge clk);
        issue(1, 0, 0, 3'd2, 32'h8000_0008, 8'h0F, rand_line(), 0, 0);
        check("t5_awaddr", awaddr, 32'h8000_0008);
        run_write(-1, 2'b00);
        check("t5_err", err, 1'b0);
        settle();

        // 6: back-to-back reads with req held
        issue(0, 0, 1, 3'd3, 32'h8000_7000, '0, '0, 1, 0);
        run_read(0, -1, -1, -1, 0, '0);
        issue(0, 1, 0, 3'd0, 32'h8000_7100, '0, '0, 0, 1);
        run_read(2, -1, -1, -1, 0, '0);
        settle();

        // randomized transactions
        for (int t = 0; t < 40; t++) begin
            b = $urandom;
            issue($urandom, b, $urandom, 3'($urandom_range(0, 3)), $urandom, $urandom,
                  rand_line(), 0, 0);
            bl_b = cur_burst ? BL - 1 : 0;
            if (wr === 1'b0 || wr === 1'b1) begin end
            if (awvalid) begin
                run_write(-1, ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00);
            end else begin
                eb = ($urandom_range(0, 3) == 0) ? $urandom_range(0, bl_b) : -1;
                run_read(2, eb, ($urandom_range(0, 4) == 0) ? $urandom_range(0, bl_b) : -1,
                         -1, 0, '0);
            end
            settle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
